// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern generator: prescaled step pulse driving flash, rotate-left,
// rotate-right and ping-pong patterns on the board LED bank.
module led_pattern_gen #(
    parameter int NB_LEDS = 4,
    parameter int NB_CNT  = 32,
    parameter int LIMIT0  = 25_000_000,
    parameter int LIMIT1  = 50_000_000,
    parameter int LIMIT2  = 100_000_000,
    parameter int LIMIT3  = 200_000_000
) (
    input  logic               clock,
    input  logic               i_reset,
    input  logic               i_valid,
    input  logic [1:0]         i_mode,
    input  logic [1:0]         i_period_sel,
    output logic [NB_LEDS-1:0] o_led,
    output logic               o_step,
    output logic               o_dir
);

    typedef enum logic [1:0] {
        MODE_FLASH = 2'b00,
        MODE_ROTL  = 2'b01,
        MODE_ROTR  = 2'b10,
        MODE_PING  = 2'b11
    } mode_t;

    localparam logic [NB_CNT-1:0]  LIM0_M1   = NB_CNT'(LIMIT0 - 1);
    localparam logic [NB_CNT-1:0]  LIM1_M1   = NB_CNT'(LIMIT1 - 1);
    localparam logic [NB_CNT-1:0]  LIM2_M1   = NB_CNT'(LIMIT2 - 1);
    localparam logic [NB_CNT-1:0]  LIM3_M1   = NB_CNT'(LIMIT3 - 1);
    localparam logic [NB_LEDS-1:0] SEED_ONE  = {{(NB_LEDS-1){1'b0}}, 1'b1};
    localparam logic [NB_LEDS-1:0] SEED_ALL  = {NB_LEDS{1'b1}};

    mode_t              mode;
    logic [NB_CNT-1:0]  cnt;
    logic [NB_CNT-1:0]  limit_m1;
    logic [NB_LEDS-1:0] next_led;
    logic               next_dir;
    logic               mode_change;

    always_comb begin
        limit_m1 = LIM0_M1;
        unique case (i_period_sel)
            2'd0: limit_m1 = LIM0_M1;
            2'd1: limit_m1 = LIM1_M1;
            2'd2: limit_m1 = LIM2_M1;
            2'd3: limit_m1 = LIM3_M1;
        endcase
    end

    assign mode_change = (mode_t'(i_mode) != mode);

    // Ping-pong flips direction in the same update that lands on an end LED,
    // so each end is lit for a single period.
    always_comb begin
        next_led = o_led;
        next_dir = o_dir;
        unique case (mode)
            MODE_FLASH: next_led = ~o_led;
            MODE_ROTL:  next_led = {o_led[NB_LEDS-2:0], o_led[NB_LEDS-1]};
            MODE_ROTR:  next_led = {o_led[0], o_led[NB_LEDS-1:1]};
            MODE_PING: begin
                if (!o_dir) begin
                    next_led = {o_led[NB_LEDS-2:0], 1'b0};
                    next_dir = o_led[NB_LEDS-2];
                end else begin
                    next_led = {1'b0, o_led[NB_LEDS-1:1]};
                    next_dir = ~o_led[1];
                end
            end
        endcase
    end

    // A mode change outranks a coincident step; the >= compare keeps a shrinking
    // period from wrapping the whole counter range.
    always_ff @(posedge clock) begin
        if (i_reset) begin
            mode   <= MODE_FLASH;
            cnt    <= '0;
            o_led  <= SEED_ALL;
            o_step <= 1'b0;
            o_dir  <= 1'b0;
        end else if (mode_change) begin
            mode   <= mode_t'(i_mode);
            cnt    <= '0;
            o_led  <= (mode_t'(i_mode) == MODE_FLASH) ? SEED_ALL : SEED_ONE;
            o_step <= 1'b0;
            o_dir  <= 1'b0;
        end else if (i_valid) begin
            if (cnt >= limit_m1) begin
                cnt    <= '0;
                o_led  <= next_led;
                o_dir  <= next_dir;
                o_step <= 1'b1;
            end else begin
                cnt    <= cnt + NB_CNT'(1);
                o_step <= 1'b0;
            end
        end else begin
            o_step <= 1'b0;
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: a position/phase based reference model pushes
// the expected post-edge outputs, and a monitor pops and compares after every edge.
module tb_led_pattern_gen;

    localparam int N = 4;

    logic         clock = 1'b0;
    logic         i_reset = 1'b1;
    logic         i_valid = 1'b0;
    logic [1:0]   i_mode = 2'b00;
    logic [1:0]   i_period_sel = 2'b00;
    logic [N-1:0] o_led;
    logic         o_step;
    logic         o_dir;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [N-1:0] led;
        logic         step;
        logic         dir;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: flash is a lit flag, rotates a one-hot index,
    // ping-pong a phase walking 0..2N-3 around the bounce.
    int m_mode  = 0;
    int m_cnt   = 0;
    int m_lit   = 1;
    int m_pos   = 0;
    int m_phase = 0;
    int m_step  = 0;

    led_pattern_gen #(
        .NB_LEDS(N), .NB_CNT(8),
        .LIMIT0(4), .LIMIT1(2), .LIMIT2(8), .LIMIT3(1)
    ) dut (
        .clock(clock), .i_reset(i_reset), .i_valid(i_valid), .i_mode(i_mode),
        .i_period_sel(i_period_sel), .o_led(o_led), .o_step(o_step), .o_dir(o_dir)
    );

    always #5 clock = ~clock;

    function automatic int limit_of(input int sel);
        case (sel)
            0: return 4;
            1: return 2;
            2: return 8;
            default: return 1;
        endcase
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        int p;
        e.step = (m_step != 0);
        e.dir  = (m_mode == 3) && (m_phase >= N - 1);
        if (m_mode == 0) begin
            e.led = (m_lit != 0) ? {N{1'b1}} : {N{1'b0}};
        end else begin
            p = (m_mode == 3) ? ((m_phase < N) ? m_phase : 2*N - 2 - m_phase) : m_pos;
            e.led = N'(1) << p;
        end
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic vld, input int mode, input int psel);
        @(negedge clock);
        i_reset      = rst;
        i_valid      = vld;
        i_mode       = 2'(mode);
        i_period_sel = 2'(psel);
        if (rst) begin
            m_mode = 0; m_cnt = 0; m_lit = 1; m_pos = 0; m_phase = 0; m_step = 0;
        end else if (mode != m_mode) begin
            m_mode = mode; m_cnt = 0; m_lit = 1; m_pos = 0; m_phase = 0; m_step = 0;
        end else if (vld) begin
            if (m_cnt + 1 >= limit_of(psel)) begin
                m_cnt  = 0;
                m_step = 1;
                case (m_mode)
                    0: m_lit = 1 - m_lit;
                    1: m_pos = (m_pos + 1) % N;
                    2: m_pos = (m_pos + N - 1) % N;
                    default: m_phase = (m_phase + 1) % (2*N - 2);
                endcase
            end else begin
                m_cnt++;
                m_step = 0;
            end
        end else begin
            m_step = 0;
        end
        exp_q.push_back(model_out());
    endtask

    // Monitor: every edge presents a fresh output word.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("sb_led",  32'(o_led),  32'(e.led));
                checkOutput("sb_step", 32'(o_step), 32'(e.step));
                checkOutput("sb_dir",  32'(o_dir),  32'(e.dir));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] ping_led [8];
        logic         ping_dir [8];
        ping_led = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
        ping_dir = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        applyStimulus(1, 0, 0, 0);
        applyStimulus(1, 0, 0, 0);
        @(posedge clock); #1;
        checkOutput("reset_led",  32'(o_led),  32'hF);
        checkOutput("reset_step", 32'(o_step), 32'h0);
        checkOutput("reset_dir",  32'(o_dir),  32'h0);

        // Flash at 4-cycle period.
        for (int i = 0; i < 12; i++) applyStimulus(0, 1, 0, 0);

        // Rotate-left then rotate-right at 2-cycle period.
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 2, 1);

        // Ping-pong stepping every cycle against the literal bounce sequence.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 1, 3, 3);
            @(posedge clock); #1;
            checkOutput("ping_led", 32'(o_led), 32'(ping_led[i]));
            checkOutput("ping_dir", 32'(o_dir), 32'(ping_dir[i]));
            checkOutput("ping_step", 32'(o_step), (i == 0) ? 32'h0 : 32'h1);
        end

        // Freeze mid-period with valid low, then resume.
        for (int i = 0; i < 2; i++)  applyStimulus(0, 1, 1, 0);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 1, 0);
        for (int i = 0; i < 8; i++)  applyStimulus(0, 1, 1, 0);

        // Shrink the period while the count sits above the new limit.
        for (int i = 0; i < 20 && m_cnt != 6; i++) applyStimulus(0, 1, 1, 2);
        for (int i = 0; i < 10; i++) applyStimulus(0, 1, 1, 0);

        // Mode change on the cycle a step is due.
        for (int i = 0; i < 10 && m_cnt != 3; i++) applyStimulus(0, 1, 1, 0);
        applyStimulus(0, 1, 2, 0);
        @(posedge clock); #1;
        checkOutput("modechg_led",  32'(o_led),  32'h1);
        checkOutput("modechg_step", 32'(o_step), 32'h0);

        // Reset while ping-pong is heading toward the LSB.
        for (int i = 0; i < 30 && !(m_mode == 3 && m_phase >= N - 1); i++) applyStimulus(0, 1, 3, 1);
        applyStimulus(1, 1, 3, 1);
        @(posedge clock); #1;
        checkOutput("midreset_led",  32'(o_led),  32'hF);
        checkOutput("midreset_dir",  32'(o_dir),  32'h0);
        checkOutput("midreset_step", 32'(o_step), 32'h0);

        // Randomised traffic.
        for (int i = 0; i < 1500; i++) begin
            int md, ps;
            md = (($urandom % 40) == 0) ? int'($urandom % 4) : m_mode;
            ps = (($urandom % 30) == 0) ? int'($urandom % 4) : int'(i_period_sel);
            applyStimulus((($urandom % 200) == 0), (($urandom % 100) < 85), md, ps);
        end

        @(posedge clock); #2;
        checkOutput("sb_drained", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
